io_sw_debounce: RTL and testbench
=================================

Name: io_sw_debounce

Overview:
Input-side peripheral for the pipelined RISC-V core; the complement of the core's output IO (LCD/LED/HEX).
- Takes raw, asynchronous board switch/button levels and synchronises and debounces them.
- Drives the clean 32-bit word the core samples on io_sw_i.
- Also produces per-bit rise/fall pulses and a sticky event register that software clears.

Parameters:
- NUM_BITS, 32: number of raw input bits, 1..32; unused upper bits of outputs are tied 0.
- SYNC_STAGES, 2: flip-flop synchroniser depth, >=2.
- TICK_DIV, 50000: clk_i cycles per sample tick (1 ms at 50 MHz), >=2.
- STABLE_CNT, 4: consecutive differing ticks required to accept a new level, >=1.

Ports:
- clk_i, input, 1: system clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- sw_raw_i, input, NUM_BITS: raw switch/button levels, asynchronous to clk_i.
- event_clr_i, input, 32: write-1-to-clear mask for sw_event_o; one-cycle pulses from the LSU.
- io_sw_o, output, 32: debounced levels, zero-extended; connects to the core's io_sw_i.
- sw_rise_o, output, 32: one-cycle pulse per bit on an accepted 0->1 change.
- sw_fall_o, output, 32: one-cycle pulse per bit on an accepted 1->0 change.
- sw_event_o, output, 32: sticky per-bit flag, set on any accepted change.
- tick_o, output, 1: sample-tick strobe, for debug and verification.

Behaviour:
- Reset (async assert, sync release by external reset logic):
  - Synchroniser flops, prescaler, per-bit counters and debounced state are cleared to 0.
  - All outputs are 0.
  - A switch held high through reset appears on io_sw_o after the normal debounce latency and produces a rise pulse and event.
- Synchroniser: SYNC_STAGES-deep flop chain per bit; sync[i] is the last stage. No logic between stages.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick_o=1 for exactly the cycle in which the counter equals TICK_DIV-1.
  - The first tick is TICK_DIV cycles after reset release.
- Per-bit debounce, evaluated only when tick_o=1; cnt has width clog2(STABLE_CNT):
  - sync==state: cnt<=0.
  - sync!=state and cnt<STABLE_CNT-1: cnt<=cnt+1.
  - sync!=state and cnt==STABLE_CNT-1: state<=sync, cnt<=0, and the edge is accepted.
  - Any tick with sync==state restarts the count, which rejects glitches shorter than STABLE_CNT ticks.
  - With STABLE_CNT=1, the first differing tick is accepted.
- Outputs:
  - io_sw_o = state, registered.
  - sw_rise_o/sw_fall_o are registered together with state. They are high exactly one cycle, the cycle io_sw_o first shows the new value.
- Latency:
  - Raw change to io_sw_o = SYNC_STAGES cycles + time to the STABLE_CNT-th following tick.
  - Range: SYNC_STAGES+(STABLE_CNT-1)*TICK_DIV+1 to SYNC_STAGES+STABLE_CNT*TICK_DIV cycles.
- Sticky events, per bit:
  - sw_event_o[i] sets on an accepted edge.
  - It clears on event_clr_i[i]=1.
  - If set and clear occur in the same cycle, set wins and no event is lost.
  - event_clr_i bits >= NUM_BITS are ignored.
- Bits are fully independent; simultaneous edges on many bits are all reported in the same cycle.
- No handshake on io_sw_o: the core samples it at will and it changes at most once per tick per bit.

Decomposition:
- Shared package io_pkg:
  - IO_WIDTH=32.
  - Default TICK_DIV and STABLE_CNT constants.
  - typedef io_word_t (logic [31:0]), shared with the output IO registers of the core.
- Sub-module sw_debounce_bit: one bit's synchroniser, counter, state and edge pulses, taking tick as an input.
- The top holds the single prescaler, a generate loop over NUM_BITS, the event register and zero-extension.

Test Plan (TICK_DIV=4, STABLE_CNT=3, SYNC_STAGES=2, NUM_BITS=8):
- Reset behaviour: assert rst_ni low mid-count with sw_raw_i=8'hFF -> all outputs 0 immediately. After release, io_sw_o=32'hFF within 2+12 cycles, sw_rise_o=32'hFF for exactly 1 cycle, sw_event_o=32'hFF.
- Clean edge: sw_raw_i[0] 0->1 and held -> io_sw_o[0]=1 between 11 and 14 cycles later, with a single-cycle sw_rise_o[0]; the later 1->0 gives a single-cycle sw_fall_o[0].
- Glitch rejection: sw_raw_i[3] high for 6 cycles (spanning <3 ticks) then low -> io_sw_o[3], sw_rise_o[3] and sw_event_o[3] stay 0.
- Bounce: sw_raw_i[5] toggling every 3 cycles for 30 cycles, then steady 1 -> exactly one rise pulse, only after the steady period contains 3 ticks.
- Event clear: with sw_event_o=32'h01, pulse event_clr_i=32'h01 -> 0 next cycle. If clear coincides with a new accepted edge on bit 0 -> stays 1. event_clr_i=32'hFFFF_FF00 -> no effect.
- Tick timing: tick_o is high every 4th cycle, first at cycle 4 after release; it never stretches beyond 1 cycle.

Source files
------------

// File: rtl/io_sw_debounce_pkg.sv
// Shared IO definitions: word width, debounce defaults, common word type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_pkg;

    localparam int IO_WIDTH        = 32;
    localparam int DEF_TICK_DIV    = 50000;  // 1 ms at 50 MHz
    localparam int DEF_STABLE_CNT  = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Same word type the core's output IO registers use.
    typedef logic [IO_WIDTH-1:0] io_word_t;

    // Counter width for a count of 0..n-1; keeps at least one bit so n=1 still elaborates.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_sw_debounce_bit.sv
// One switch bit: flop synchroniser, tick-gated stability counter, debounced level, edge pulses.
// Latency: SYNC_STAGES cycles plus up to STABLE_CNT ticks from raw change to state_o.
// Backpressure: none; state_o may be sampled at any time and changes at most once per tick.
module sw_debounce_bit
    import io_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    input  logic tick_i,
    output logic state_o,
    output logic rise_o,
    output logic fall_o,
    output logic acc_o
);

    localparam int            CW       = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_s;
    logic                   acc;

    // Plain shift chain: raw enters stage 0, the last stage is the synchronised level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Count consecutive ticks that disagree with the debounced level; accept on the last one.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        acc     = 1'b0;
        if (tick_i) begin
            if (sync_s == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = sync_s;
                cnt_d   = '0;
                acc     = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise_d = acc & sync_s;
        fall_d = acc & ~sync_s;
    end

    // Edge pulses are registered alongside state so they line up with the new level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign state_o = state_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign acc_o   = acc;

endmodule

// File: rtl/io_sw_debounce.sv
// Switch/button input block: shared sample prescaler, per-bit debounce, sticky W1C event flags.
// Latency: SYNC_STAGES+(STABLE_CNT-1)*TICK_DIV+1 .. SYNC_STAGES+STABLE_CNT*TICK_DIV cycles.
// Backpressure: none; io_sw_o is a level the core samples at will, events hold until cleared.
module io_sw_debounce
    import io_pkg::*;
#(
    parameter int NUM_BITS    = 32,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_BITS-1:0] sw_raw_i,
    input  io_word_t            event_clr_i,
    output io_word_t            io_sw_o,
    output io_word_t            sw_rise_o,
    output io_word_t            sw_fall_o,
    output io_word_t            sw_event_o,
    output logic                tick_o
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic [NUM_BITS-1:0] state_v, rise_v, fall_v, acc_v;
    io_word_t            state_w, rise_w, fall_w, acc_w;
    io_word_t            event_q, event_d;

    assign tick = (presc_q == PRESC_LAST);

    // Free-running 0..TICK_DIV-1 prescaler; tick is the single wrap cycle.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BITS; gi++) begin : g_bit
            sw_debounce_bit #(
                .SYNC_STAGES (SYNC_STAGES),
                .STABLE_CNT  (STABLE_CNT)
            ) u_bit (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .raw_i   (sw_raw_i[gi]),
                .tick_i  (tick),
                .state_o (state_v[gi]),
                .rise_o  (rise_v[gi]),
                .fall_o  (fall_v[gi]),
                .acc_o   (acc_v[gi])
            );
        end
    endgenerate

    // Zero-extend per-bit vectors to the full IO word; upper bits never set.
    always_comb begin
        state_w                 = '0;
        rise_w                  = '0;
        fall_w                  = '0;
        acc_w                   = '0;
        state_w[NUM_BITS-1:0]   = state_v;
        rise_w[NUM_BITS-1:0]    = rise_v;
        fall_w[NUM_BITS-1:0]    = fall_v;
        acc_w[NUM_BITS-1:0]     = acc_v;
    end

    // Sticky events: an accepted edge sets the flag even if a clear lands in the same cycle.
    always_comb begin
        event_d = acc_w | (event_q & ~event_clr_i);
    end

    // Prescaler and event register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            event_q <= '0;
        end else begin
            presc_q <= presc_d;
            event_q <= event_d;
        end
    end

    assign io_sw_o    = state_w;
    assign sw_rise_o  = rise_w;
    assign sw_fall_o  = fall_w;
    assign sw_event_o = event_q;
    assign tick_o     = tick;

endmodule

// File: tb/tb_io_sw_debounce.sv
// Directed bench for io_sw_debounce with TICK_DIV=4, STABLE_CNT=3, SYNC_STAGES=2, NUM_BITS=8.
// Latency: expected edges land 11..14 cycles after a raw change.
// Backpressure: n/a.
module tb_io_sw_debounce;
    import io_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_raw;
    io_word_t   event_clr;
    io_word_t   io_sw, sw_rise, sw_fall, sw_event;
    logic       tick;

    int tests = 0;
    int fails = 0;

    int          first_io, n_rise, n_fall, rise_at, fall_at;
    logic [31:0] rise_val;
    logic [15:0] tick_bits;
    logic        seen;
    int          pre, got;

    always #5 clk = ~clk;

    io_sw_debounce #(
        .NUM_BITS    (8),
        .SYNC_STAGES (2),
        .TICK_DIV    (4),
        .STABLE_CNT  (3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sw_raw_i    (sw_raw),
        .event_clr_i (event_clr),
        .io_sw_o     (io_sw),
        .sw_rise_o   (sw_rise),
        .sw_fall_o   (sw_fall),
        .sw_event_o  (sw_event),
        .tick_o      (tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] raw);
        sw_raw = raw;
        rst_n  = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_clr(input io_word_t m);
        event_clr = m;
        step();
        event_clr = '0;
    endtask

    // Run n cycles, noting when bit b first reads tgt and the edge pulses seen on it.
    task automatic watch(input int b, input logic tgt, input int n);
        first_io = -1; n_rise = 0; n_fall = 0; rise_at = -1; fall_at = -1;
        for (int k = 1; k <= n; k++) begin
            step();
            if (first_io < 0 && io_sw[b] === tgt) first_io = k;
            if (sw_rise[b]) begin
                n_rise++;
                if (rise_at < 0) rise_at = k;
            end
            if (sw_fall[b]) begin
                n_fall++;
                if (fall_at < 0) fall_at = k;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sw_raw    = '0;
        event_clr = '0;

        // Reset state
        step();
        step();
        check("rst_io_sw", io_sw, 32'h0);
        check("rst_event", sw_event, 32'h0);
        check("rst_tick", {31'b0, tick}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) step();
        check("idle_io_sw", io_sw, 32'h0);

        // Debounce all bits high, then reset mid-count with the switches still high
        sw_raw = 8'hFF;
        for (int k = 0; k < 20; k++) step();
        check("pre_rst_io_sw", io_sw, 32'hFF);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_io_sw", io_sw, 32'h0);
        check("async_rst_rise", sw_rise | sw_fall, 32'h0);
        check("async_rst_event", sw_event, 32'h0);
        check("async_rst_tick", {31'b0, tick}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        first_io = -1; n_rise = 0; rise_at = -1; rise_val = '0; tick_bits = '0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k <= 16) tick_bits[k-1] = tick;
            if (first_io < 0 && io_sw == 32'hFF) first_io = k;
            if (sw_rise != 0) begin
                n_rise++;
                if (rise_at < 0) begin
                    rise_at  = k;
                    rise_val = sw_rise;
                end
            end
        end
        check("held_io_sw_cycle", first_io, 12);
        check("held_rise_cycle", rise_at, 12);
        check("held_rise_val", rise_val, 32'hFF);
        check("held_rise_count", n_rise, 1);
        check("held_event", sw_event, 32'hFF);
        check("tick_pattern", {16'b0, tick_bits}, 32'h4444);

        // Clean rise and fall on bit 0
        do_reset(8'h00);
        for (int k = 0; k < 5; k++) step();
        sw_raw[0] = 1'b1;
        watch(0, 1'b1, 20);
        check("edge_rise_window", {31'b0, (first_io >= 11 && first_io <= 14)}, 32'h1);
        check("edge_rise_aligned", rise_at, first_io);
        check("edge_rise_count", n_rise, 1);
        check("edge_rise_no_fall", n_fall, 0);
        check("edge_rise_io_sw", io_sw, 32'h1);
        check("edge_rise_event", sw_event, 32'h1);
        sw_raw[0] = 1'b0;
        watch(0, 1'b0, 20);
        check("edge_fall_window", {31'b0, (first_io >= 11 && first_io <= 14)}, 32'h1);
        check("edge_fall_aligned", fall_at, first_io);
        check("edge_fall_count", n_fall, 1);
        check("edge_fall_no_rise", n_rise, 0);
        check("edge_fall_io_sw", io_sw, 32'h0);

        // Glitch on bit 3 shorter than three ticks
        step();
        step();
        seen = 1'b0;
        sw_raw[3] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            seen = seen | io_sw[3] | sw_rise[3] | sw_event[3];
        end
        sw_raw[3] = 1'b0;
        for (int k = 0; k < 24; k++) begin
            step();
            seen = seen | io_sw[3] | sw_rise[3] | sw_event[3];
        end
        check("glitch_rejected", {31'b0, seen}, 32'h0);

        // Bounce on bit 5, phase-locked to the prescaler, then steady high
        got = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (tick) begin
                got = k;
                break;
            end
        end
        check("tick_found", {31'b0, (got > 0)}, 32'h1);
        step();
        pre = 0;
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) sw_raw[5] = ~sw_raw[5];
            step();
            if (sw_rise[5] || io_sw[5]) pre++;
        end
        sw_raw[5] = 1'b1;
        watch(5, 1'b1, 25);
        check("bounce_no_early", pre, 0);
        check("bounce_rise_count", n_rise, 1);
        check("bounce_rise_cycle", rise_at, 14);
        check("bounce_io_sw", io_sw, 32'h21 & 32'h20);

        // Sticky events and write-1-to-clear
        check("event_before_clr", sw_event, 32'h21);
        pulse_clr(32'h20);
        check("event_clr_bit5", sw_event, 32'h01);
        pulse_clr(32'hFFFF_FF00);
        check("event_clr_upper", sw_event, 32'h01);
        pulse_clr(32'h01);
        check("event_clr_bit0", sw_event, 32'h00);

        // Clear held through the accept cycle of a new edge: the set must survive
        sw_raw[0] = 1'b1;
        event_clr = 32'h1;
        got = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (io_sw[0]) begin
                got = k;
                check("clr_vs_set", {31'b0, sw_event[0]}, 32'h1);
                event_clr = '0;
                break;
            end
        end
        event_clr = '0;
        check("clr_vs_set_window", {31'b0, (got >= 11 && got <= 14)}, 32'h1);
        step();
        check("clr_vs_set_kept", sw_event, 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
